dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder that serves the Memory stage of the pipelined RV32 core.
- The Memory stage issues load/store requests over a valid/ready interface; this block holds the data RAM, applies a fixed access latency, and returns load data.
  - Load data is sign- or zero-extended according to the access size and sign control.
- stall_o tells the hazard logic to freeze the F/D/E/M pipeline registers while an access is outstanding.

Parameters:
- DATA_WIDTH, 32, data/address bus width.
- ADDR_WIDTH, 17, byte-address bits decoded by the RAM; RAM size is 2**ADDR_WIDTH bytes.
- LATENCY, 2, clock edges from request acceptance to response; legal range 1..15.

Ports:
- clk  input  1  clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  block can accept a request this cycle.
- req_write_i  input  1  1 = store, 0 = load.
- req_addr_i  input  DATA_WIDTH  byte address (ALUResultM).
- req_wdata_i  input  DATA_WIDTH  store data (WriteDataM), right-aligned.
- req_type_i  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- req_sign_i  input  1  1 = sign-extend load, 0 = zero-extend.
- resp_valid_o  output  1  one-cycle response strobe.
- resp_rdata_o  output  DATA_WIDTH  extended load data; 0 for stores and errors.
- resp_err_o  output  1  misaligned or illegal access, qualified by resp_valid_o.
- stall_o  output  1  high while the FSM is not IDLE.

Behaviour:
- Reset state:
  - Synchronous reset: FSM to IDLE, latency counter to 0.
  - Outputs after reset: req_ready_o=1, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, stall_o=0.
  - RAM contents are not reset.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i & req_ready_o: capture write, addr, wdata, type and sign; load counter with LATENCY-1; go to BUSY.
- BUSY:
  - req_ready_o=0; counter decrements each edge.
  - At the edge where counter==0, the access executes:
    - Stores write their byte lanes at this edge.
    - Loads read the RAM combinationally before this edge and register the extended data.
  - The FSM then goes to RESP.
- RESP:
  - resp_valid_o=1 for exactly this one cycle, with rdata/err valid.
  - req_ready_o=0; next state IDLE.
- Timing:
  - Acceptance at edge N gives resp_valid_o high in the cycle after edge N+LATENCY.
  - Throughput is one request per LATENCY+2 cycles.
- stall_o = (state != IDLE). It is registered-state derived; there is no combinational path from req_valid_i.
- Addressing:
  - The RAM index is req_addr_i[ADDR_WIDTH-1:0]; upper bits are ignored, so addresses wrap modulo the RAM size.
  - Little-endian byte order.
- Alignment:
  - half requires addr[0]=0; word requires addr[1:0]=00.
  - A violation, or type 11, gives resp_err_o=1 and resp_rdata_o=0, with no RAM write and the same latency.
- Store lanes:
  - byte writes wdata[7:0] to addr.
  - half writes wdata[15:0] to addr, addr+1.
  - word writes wdata[31:0] to addr..addr+3.
- Load extension:
  - byte: bit 7 replicated if sign=1, else zeros.
  - half: bit 15 replicated if sign=1, else zeros.
  - word: passed unchanged.
- Store response: resp_valid_o still pulses, with resp_rdata_o=0 and resp_err_o=0.
- Hazard ordering: a load following a store to the same address returns the new data, because the store commits before the next acceptance.
- Reset mid-operation: the pending request is dropped, no write is committed, and no response is issued.
- req_valid_i while not ready is ignored; the requester must hold the request until it is accepted.
- resp_rdata_o and resp_err_o hold their value outside RESP, but are meaningful only when resp_valid_o=1.

Optional Feature:
- Macro: DMEM_STATS_EN.
- When defined:
  - Adds outputs load_count_o [31:0] and store_count_o [31:0].
  - Each increments on the acceptance edge of a non-error load or store respectively.
  - Counters saturate at 32'hFFFFFFFF and reset to 0.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle: assert rst for 2 cycles -> req_ready_o=1, stall_o=0, resp_valid_o=0.
- Word store/load with LATENCY=2:
  - Store 0xDEADBEEF at 0x100, then load word 0x100.
  - Load resp_rdata_o=0xDEADBEEF, resp_valid_o exactly 3 cycles after acceptance, stall_o high for those 3 cycles.
- Byte/half extension, memory word 0x8001_80FF at 0x200:
  - lb 0x200 -> 0xFFFFFFFF; lbu 0x200 -> 0x000000FF.
  - lh 0x202 -> 0xFFFF8001; lhu 0x200 -> 0x000080FF.
- Partial store:
  - sb 0xAA at 0x201 over 0x11223344 -> lw 0x200 returns 0x1122AA44.
  - sh 0xBEEF at 0x202 -> lw 0x200 returns 0xBEEFAA44.
- Misaligned access:
  - lw 0x102 -> resp_err_o=1, resp_rdata_o=0.
  - sh at 0x101 -> resp_err_o=1, and a subsequent lw 0x100 is unchanged.
- Reset mid-BUSY:
  - Store 0x12345678 to 0x300, assert rst one cycle after acceptance.
  - No resp_valid_o pulse; lw 0x300 returns the prior value.
  - With DMEM_STATS_EN defined, store_count_o=0 after the reset.

Source files
------------

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Data-memory responder for the Memory stage of a pipelined
//                RV32 core. Accepts one load/store request at a time over a
//                valid/ready handshake, holds a byte-addressed data RAM, and
//                answers after a fixed latency with extended load data or an
//                error flag for misaligned/illegal accesses.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DATA_WIDTH   data/address bus width (the lane logic assumes 32)
//    ADDR_WIDTH   byte-address bits decoded by the RAM (2**ADDR_WIDTH bytes)
//    LATENCY      clock edges from acceptance to response, 1..15
//  Ports
//    clk, rst                  clock, synchronous active-high reset
//    req_valid_i / req_ready_o request handshake
//    req_write_i               1 = store, 0 = load
//    req_addr_i                byte address (upper bits beyond ADDR_WIDTH ignored)
//    req_wdata_i               right-aligned store data
//    req_type_i                00 byte, 01 half, 10 word, 11 illegal
//    req_sign_i                1 = sign-extend load data
//    resp_valid_o              one-cycle response strobe
//    resp_rdata_o              extended load data (0 for stores/errors)
//    resp_err_o                misaligned or illegal access
//    stall_o                   high while an access is outstanding
//  Optional build macro
//    DMEM_STATS_EN             adds saturating load_count_o / store_count_o
// ============================================================================
module dmem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 17,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [DATA_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [1:0]            req_type_i,
    input  logic                  req_sign_i,
    output logic                  resp_valid_o,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  resp_err_o,
`ifdef DMEM_STATS_EN
    output logic                  stall_o,
    output logic [31:0]           load_count_o,
    output logic [31:0]           store_count_o
`else
    output logic                  stall_o
`endif
);

    localparam int         WORDS   = 2 ** (ADDR_WIDTH - 2);
    localparam logic [3:0] LAT_M1  = 4'(LATENCY - 1);

    localparam logic [1:0] TYPE_BYTE = 2'b00;
    localparam logic [1:0] TYPE_HALF = 2'b01;
    localparam logic [1:0] TYPE_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Misaligned half/word or the illegal size code.
    function automatic logic access_err(input logic [1:0] t, input logic [1:0] a);
        logic e;
        e = 1'b0;
        case (t)
            TYPE_BYTE: e = 1'b0;
            TYPE_HALF: e = a[0];
            TYPE_WORD: e = (a != 2'b00);
            default:   e = 1'b1;
        endcase
        return e;
    endfunction

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    write_q, write_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [1:0]              type_q, type_d;
    logic                    sign_q, sign_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic                    exec;
    logic                    cur_err;
    logic [ADDR_WIDTH-3:0]   word_idx;
    logic [31:0]             rd_word;
    logic [31:0]             wr_word;
    logic [3:0]              lane_we;
    logic [7:0]              ld_byte;
    logic [15:0]             ld_half;
    logic [DATA_WIDTH-1:0]   load_ext;

    // Address bits above the RAM decode are deliberately discarded (wrap).
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr_i[DATA_WIDTH-1:ADDR_WIDTH];

    assign cur_err  = access_err(type_q, addr_q[1:0]);
    assign word_idx = addr_q[ADDR_WIDTH-1:2];

    // ------------------------------------------------------------------------
    // Control FSM: next state, capture and response data
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        type_d      = type_q;
        sign_d      = sign_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        req_ready_o = 1'b0;
        exec        = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    write_d = req_write_i;
                    addr_d  = req_addr_i[ADDR_WIDTH-1:0];
                    wdata_d = req_wdata_i;
                    type_d  = req_type_i;
                    sign_d  = req_sign_i;
                    cnt_d   = LAT_M1;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q == 4'd0) begin
                    exec    = 1'b1;
                    err_d   = cur_err;
                    rdata_d = (write_q || cur_err) ? '0 : load_ext;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            type_q  <= 2'b00;
            sign_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            type_q  <= type_d;
            sign_q  <= sign_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign resp_valid_o = (state_q == S_RESP);
    assign stall_o      = (state_q != S_IDLE);
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;

    // ------------------------------------------------------------------------
    // Store lane steering. Accesses are aligned, so a half or word never
    // straddles a RAM word and each lane is written at most once.
    // ------------------------------------------------------------------------
    always_comb begin
        lane_we = 4'b0000;
        wr_word = wdata_q[31:0];
        case (type_q)
            TYPE_BYTE: begin
                wr_word = {4{wdata_q[7:0]}};
                lane_we = 4'b0001 << addr_q[1:0];
            end
            TYPE_HALF: begin
                wr_word = {2{wdata_q[15:0]}};
                lane_we = addr_q[1] ? 4'b1100 : 4'b0011;
            end
            TYPE_WORD: begin
                lane_we = 4'b1111;
            end
            default: begin
                lane_we = 4'b0000;
            end
        endcase
        // Reset on the commit edge must also suppress the write.
        if (!(exec && write_q && !cur_err && !rst)) begin
            lane_we = 4'b0000;
        end
    end

    // One byte-wide bank per lane, indexed by word address; read is async.
    generate
        for (genvar l = 0; l < 4; l++) begin : g_lane
            logic [7:0] mem [WORDS];

            always_ff @(posedge clk) begin
                if (lane_we[l]) begin
                    mem[word_idx] <= wr_word[8*l +: 8];
                end
            end

            assign rd_word[8*l +: 8] = mem[word_idx];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Load extraction and extension (little-endian)
    // ------------------------------------------------------------------------
    always_comb begin
        ld_byte = rd_word[7:0];
        case (addr_q[1:0])
            2'd0:    ld_byte = rd_word[7:0];
            2'd1:    ld_byte = rd_word[15:8];
            2'd2:    ld_byte = rd_word[23:16];
            default: ld_byte = rd_word[31:24];
        endcase
        ld_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

        load_ext = rd_word;
        case (type_q)
            TYPE_BYTE: load_ext = {{24{sign_q & ld_byte[7]}}, ld_byte};
            TYPE_HALF: load_ext = {{16{sign_q & ld_half[15]}}, ld_half};
            default:   load_ext = rd_word;
        endcase
    end

`ifdef DMEM_STATS_EN
    // ------------------------------------------------------------------------
    // Saturating access counters, bumped on the acceptance edge of
    // error-free requests only.
    // ------------------------------------------------------------------------
    logic [31:0] load_count_q, load_count_d;
    logic [31:0] store_count_q, store_count_d;
    logic        acc_ok;

    assign acc_ok = (state_q == S_IDLE) && req_valid_i &&
                    !access_err(req_type_i, req_addr_i[1:0]);

    always_comb begin
        load_count_d  = load_count_q;
        store_count_d = store_count_q;
        if (acc_ok && req_write_i && (store_count_q != 32'hFFFF_FFFF)) begin
            store_count_d = store_count_q + 32'd1;
        end
        if (acc_ok && !req_write_i && (load_count_q != 32'hFFFF_FFFF)) begin
            load_count_d = load_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            load_count_q  <= 32'd0;
            store_count_q <= 32'd0;
        end else begin
            load_count_q  <= load_count_d;
            store_count_q <= store_count_d;
        end
    end

    assign load_count_o  = load_count_q;
    assign store_count_o = store_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Self-checking bench for dmem_responder. Directed scenarios
//                plus randomized traffic checked against a byte-array memory
//                model with arithmetic load extension.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [1:0]  req_type_i;
    logic        req_sign_i;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic        stall_o;
`ifdef DMEM_STATS_EN
    logic [31:0] load_count_o;
    logic [31:0] store_count_o;
`endif

    always #5 clk = ~clk;

    dmem_responder #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(17),
        .LATENCY   (LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_write_i  (req_write_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .req_type_i   (req_type_i),
        .req_sign_i   (req_sign_i),
        .resp_valid_o (resp_valid_o),
        .resp_rdata_o (resp_rdata_o),
        .resp_err_o   (resp_err_o),
`ifdef DMEM_STATS_EN
        .stall_o      (stall_o),
        .load_count_o (load_count_o),
        .store_count_o(store_count_o)
`else
        .stall_o      (stall_o)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: sparse byte memory plus access counters.
    logic [7:0] ref_mem [logic [16:0]];
    int         exp_loads  = 0;
    int         exp_stores = 0;

    function automatic logic model_err(input logic [1:0] t, input logic [31:0] a);
        return (t == 2'b11) || (t == 2'b01 && a[0]) || (t == 2'b10 && a[1:0] != 2'b00);
    endfunction

    function automatic int size_bytes(input logic [1:0] t);
        return (t == 2'b00) ? 1 : (t == 2'b01) ? 2 : 4;
    endfunction

    task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] wd,
                                input logic [1:0] t, input logic s,
                                output logic [31:0] exp, output logic exp_err,
                                output logic known);
        logic [31:0] v;
        logic [16:0] key;
        exp     = 32'd0;
        exp_err = model_err(t, a);
        known   = 1'b1;
        v       = 32'd0;
        if (!exp_err) begin
            if (w) begin
                exp_stores++;
                for (int i = 0; i < size_bytes(t); i++) begin
                    key = 17'(a + 32'(i));
                    ref_mem[key] = wd[8*i +: 8];
                end
            end else begin
                exp_loads++;
                for (int i = 0; i < size_bytes(t); i++) begin
                    key = 17'(a + 32'(i));
                    if (ref_mem.exists(key)) v[8*i +: 8] = ref_mem[key];
                    else known = 1'b0;
                end
                if (t == 2'b00)      exp = s ? 32'($signed(v[7:0]))  : 32'(v[7:0]);
                else if (t == 2'b01) exp = s ? 32'($signed(v[15:0])) : 32'(v[15:0]);
                else                 exp = v;
            end
        end
    endtask

    // Drives one request, waits for acceptance and the response strobe.
    // lat counts negedges after the acceptance edge up to the strobe.
    task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] wd,
                             input logic [1:0] t, input logic s,
                             output logic [31:0] rd, output logic er,
                             output int lat, output logic stall_ok);
        int guard;
        @(negedge clk);
        req_write_i = w;
        req_addr_i  = a;
        req_wdata_i = wd;
        req_type_i  = t;
        req_sign_i  = s;
        req_valid_i = 1'b1;
        guard = 0;
        while (!req_ready_o && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        lat      = 0;
        stall_ok = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (!stall_o) stall_ok = 1'b0;
        end while (!resp_valid_o && lat < 50);
        rd = resp_rdata_o;
        er = resp_err_o;
    endtask

    // Model + DUT for one access.
    task automatic run(input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] t, input logic s,
                       output logic [31:0] rd, output logic er, output int lat,
                       output logic stall_ok, output logic [31:0] exp,
                       output logic exp_err, output logic known);
        model_access(w, a, wd, t, s, exp, exp_err, known);
        do_access(w, a, wd, t, s, rd, er, lat, stall_ok);
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst         = 1'b1;
        req_valid_i = 1'b0;
        req_write_i = 1'b0;
        req_addr_i  = 32'd0;
        req_wdata_i = 32'd0;
        req_type_i  = 2'b00;
        req_sign_i  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_loads  = 0;
        exp_stores = 0;
        checks++;
        if (req_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", req_ready_o); end
        checks++;
        if (stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b want=0", stall_o); end
        checks++;
        if (resp_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", resp_valid_o); end
        checks++;
        if (resp_rdata_o !== 32'd0 || resp_err_o !== 1'b0) begin
            failures++; $display("FAIL reset_resp got=%h/%b want=0/0", resp_rdata_o, resp_err_o);
        end
    endtask

    task automatic test_word_store_load();
        logic [31:0] rd, exp; logic er, sok, eer, kn; int lat;
        run(1'b1, 32'h100, 32'hDEADBEEF, 2'b10, 1'b0, rd, er, lat, sok, exp, eer, kn);
        checks++;
        if (rd !== 32'd0 || er !== 1'b0) begin failures++; $display("FAIL sw_resp got=%h/%b want=0/0", rd, er); end
        checks++;
        if (lat !== LAT + 1) begin failures++; $display("FAIL sw_latency got=%0d want=%0d", lat, LAT + 1); end
        run(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, rd, er, lat, sok, exp, eer, kn);
        checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin failures++; $display("FAIL lw_data got=%h/%b want=deadbeef/0", rd, er); end
        checks++;
        if (lat !== LAT + 1) begin failures++; $display("FAIL lw_latency got=%0d want=%0d", lat, LAT + 1); end
        checks++;
        if (sok !== 1'b1) begin failures++; $display("FAIL lw_stall got=%b want=1", sok); end
        // stall must drop in the cycle after the response
        @(negedge clk);
        checks++;
        if (stall_o !== 1'b0 || req_ready_o !== 1'b1) begin
            failures++; $display("FAIL post_resp_idle got stall=%b ready=%b want 0/1", stall_o, req_ready_o);
        end
    endtask

    task automatic test_extension();
        logic [31:0] rd, exp; logic er, sok, eer, kn; int lat;
        logic [31:0] addrs [4];
        logic [1:0]  types [4];
        logic        signs [4];
        logic [31:0] want  [4];
        addrs = '{32'h200, 32'h200, 32'h202, 32'h200};
        types = '{2'b00, 2'b00, 2'b01, 2'b01};
        signs = '{1'b1, 1'b0, 1'b1, 1'b0};
        want  = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF8001, 32'h000080FF};
        run(1'b1, 32'h200, 32'h800180FF, 2'b10, 1'b0, rd, er, lat, sok, exp, eer, kn);
        for (int i = 0; i < 4; i++) begin
            run(1'b0, addrs[i], 32'h0, types[i], signs[i], rd, er, lat, sok, exp, eer, kn);
            checks++;
            if (rd !== want[i] || er !== 1'b0) begin
                failures++; $display("FAIL ext_%0d got=%h/%b want=%h/0", i, rd, er, want[i]);
            end
            checks++;
            if (rd !== exp) begin failures++; $display("FAIL ext_model_%0d got=%h want=%h", i, rd, exp); end
        end
    endtask

    task automatic test_partial_store();
        logic [31:0] rd, exp; logic er, sok, eer, kn; int lat;
        run(1'b1, 32'h200, 32'h11223344, 2'b10, 1'b0, rd, er, lat, sok, exp, eer, kn);
        run(1'b1, 32'h201, 32'h000000AA, 2'b00, 1'b0, rd, er, lat, sok, exp, eer, kn);
        run(1'b0, 32'h200, 32'h0, 2'b10, 1'b0, rd, er, lat, sok, exp, eer, kn);
        checks++;
        if (rd !== 32'h1122AA44) begin failures++; $display("FAIL sb_merge got=%h want=1122aa44", rd); end
        run(1'b1, 32'h202, 32'h0000BEEF, 2'b01, 1'b0, rd, er, lat, sok, exp, eer, kn);
        run(1'b0, 32'h200, 32'h0, 2'b10, 1'b0, rd, er, lat, sok, exp, eer, kn);
        checks++;
        if (rd !== 32'hBEEFAA44) begin failures++; $display("FAIL sh_merge got=%h want=beefaa44", rd); end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd, exp; logic er, sok, eer, kn; int lat;
        run(1'b0, 32'h102, 32'h0, 2'b10, 1'b1, rd, er, lat, sok, exp, eer, kn);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin failures++; $display("FAIL lw_misaligned got=%h/%b want=0/1", rd, er); end
        checks++;
        if (lat !== LAT + 1) begin failures++; $display("FAIL err_latency got=%0d want=%0d", lat, LAT + 1); end
        run(1'b1, 32'h101, 32'h0000FFFF, 2'b01, 1'b0, rd, er, lat, sok, exp, eer, kn);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin failures++; $display("FAIL sh_misaligned got=%h/%b want=0/1", rd, er); end
        run(1'b0, 32'h100, 32'h0, 2'b11, 1'b0, rd, er, lat, sok, exp, eer, kn);
        checks++;
        if (er !== 1'b1) begin failures++; $display("FAIL illegal_type got=%b want=1", er); end
        run(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, rd, er, lat, sok, exp, eer, kn);
        checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin failures++; $display("FAIL after_bad_sh got=%h/%b want=deadbeef/0", rd, er); end
    endtask

    task automatic test_back_to_back();
        int acc [$];
        int cyc;
        int pulses;
        logic data_ok;
        @(negedge clk);
        req_write_i = 1'b0;
        req_addr_i  = 32'h100;
        req_type_i  = 2'b10;
        req_sign_i  = 1'b0;
        req_valid_i = 1'b1;
        cyc = 0; pulses = 0; data_ok = 1'b1;
        while (acc.size() < 3 && cyc < 40) begin
            if (resp_valid_o) begin
                pulses++;
                if (resp_rdata_o !== 32'hDEADBEEF) data_ok = 1'b0;
            end
            if (req_ready_o) acc.push_back(cyc);
            if (acc.size() < 3) begin @(negedge clk); cyc++; end
        end
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        repeat (LAT + 2) begin
            @(negedge clk);
            if (resp_valid_o) begin
                pulses++;
                if (resp_rdata_o !== 32'hDEADBEEF) data_ok = 1'b0;
            end
        end
        exp_loads += 3;
        checks++;
        if (acc.size() != 3 || acc[1] - acc[0] != LAT + 2 || acc[2] - acc[1] != LAT + 2) begin
            failures++;
            $display("FAIL throughput accepts=%0d gaps=%0d,%0d want gap %0d", acc.size(),
                     acc.size() > 1 ? acc[1] - acc[0] : -1, acc.size() > 2 ? acc[2] - acc[1] : -1, LAT + 2);
        end
        checks++;
        if (pulses != 3 || !data_ok) begin failures++; $display("FAIL b2b_resp pulses=%0d data_ok=%b want 3/1", pulses, data_ok); end
    endtask

    task automatic test_random();
        logic [31:0] rd, exp, a, wd; logic er, sok, eer, kn, w, s; logic [1:0] t; int lat;
        int bad_val, bad_err, bad_lat;
        bad_val = 0; bad_err = 0; bad_lat = 0;
        for (int i = 0; i < 64; i++) begin
            a = ($urandom & 32'hFFFE_0000) | (32'h1000 + 32'(i * 4));
            run(1'b1, a, $urandom, 2'b10, 1'b0, rd, er, lat, sok, exp, eer, kn);
        end
        for (int i = 0; i < 80; i++) begin
            a  = ($urandom & 32'hFFFE_0000) | (32'h1000 + 32'($urandom_range(0, 255)));
            w  = 1'($urandom_range(0, 1));
            t  = 2'($urandom_range(0, 3));
            s  = 1'($urandom_range(0, 1));
            wd = $urandom;
            run(w, a, wd, t, s, rd, er, lat, sok, exp, eer, kn);
            if (er !== eer) bad_err++;
            if (lat != LAT + 1 || !sok) bad_lat++;
            if (kn && rd !== exp) begin
                bad_val++;
                if (bad_val < 4) $display("FAIL rand_op%0d w=%b t=%0d a=%h got=%h want=%h", i, w, t, a, rd, exp);
            end
        end
        checks++;
        if (bad_val != 0) begin failures++; $display("FAIL rand_data bad=%0d want=0", bad_val); end
        checks++;
        if (bad_err != 0) begin failures++; $display("FAIL rand_err bad=%0d want=0", bad_err); end
        checks++;
        if (bad_lat != 0) begin failures++; $display("FAIL rand_latency bad=%0d want=0", bad_lat); end
    endtask

    task automatic test_stats();
`ifdef DMEM_STATS_EN
        checks++;
        if (load_count_o !== 32'(exp_loads)) begin failures++; $display("FAIL load_count got=%0d want=%0d", load_count_o, exp_loads); end
        checks++;
        if (store_count_o !== 32'(exp_stores)) begin failures++; $display("FAIL store_count got=%0d want=%0d", store_count_o, exp_stores); end
`endif
    endtask

    task automatic test_reset_mid_busy();
        logic [31:0] rd, exp; logic er, sok, eer, kn; int lat;
        int seen;
        run(1'b1, 32'h300, 32'hCAFEF00D, 2'b10, 1'b0, rd, er, lat, sok, exp, eer, kn);
        @(negedge clk);
        req_write_i = 1'b1;
        req_addr_i  = 32'h300;
        req_wdata_i = 32'h12345678;
        req_type_i  = 2'b10;
        req_valid_i = 1'b1;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_loads  = 0;
        exp_stores = 0;
        seen = 0;
        repeat (LAT + 3) begin
            @(negedge clk);
            if (resp_valid_o) seen++;
        end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL mid_reset_pulse got=%0d want=0", seen); end
        checks++;
        if (req_ready_o !== 1'b1 || stall_o !== 1'b0) begin
            failures++; $display("FAIL mid_reset_idle ready=%b stall=%b want 1/0", req_ready_o, stall_o);
        end
`ifdef DMEM_STATS_EN
        checks++;
        if (store_count_o !== 32'd0) begin failures++; $display("FAIL mid_reset_store_count got=%0d want=0", store_count_o); end
`endif
        run(1'b0, 32'h300, 32'h0, 2'b10, 1'b0, rd, er, lat, sok, exp, eer, kn);
        checks++;
        if (rd !== 32'hCAFEF00D) begin failures++; $display("FAIL mid_reset_data got=%h want=cafef00d", rd); end
    endtask

    initial begin
        test_reset();
        test_word_store_load();
        test_extension();
        test_partial_store();
        test_misaligned();
        test_back_to_back();
        test_random();
        test_stats();
        test_reset_mid_busy();
        test_stats();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
